aria_lt_s1_seq: RTL and testbench

Iterative forward ARIA S1 substitution engine. It accepts a 128-bit state word and applies S1 (GF(2^8) inverse, then the AES affine map with constant 0x63) to all 16 bytes, BPC bytes per clock. It is the encrypt-direction counterpart of the existing inverse-S1 path. It sits in the round datapath between key addition and the diffusion layer, with valid/ready handshakes on both sides.

---
 rtl/aria_lt_pkg.sv | 21 ++
 rtl/aria_lt_gfinv.sv | 36 +++
 rtl/aria_lt_s1.sv | 25 ++
 rtl/aria_lt_s1_seq.sv | 106 ++++++++++
 tb/tb_aria_lt_s1_seq.sv | 258 +++++++++++++++++++++++++
 5 files changed

// File: rtl/aria_lt_pkg.sv
// Shared definitions for the ARIA substitution-layer engines.
package aria_lt_pkg;

  localparam logic [7:0] S1_CONST = 8'h63;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUB  = 2'd1,
    DONE = 2'd2
  } lt_state_e;

  // Byte 0 occupies [127:120], so byte idx starts at bit 120 - 8*idx.
  function automatic int byte_lsb(input int idx);
    return 120 - 8 * idx;
  endfunction

  function automatic bit bpc_legal(input int bpc);
    return (bpc == 1) || (bpc == 2) || (bpc == 4) || (bpc == 8) || (bpc == 16);
  endfunction

endpackage

// File: rtl/aria_lt_gfinv.sv
// Combinational GF(2^8) multiplicative inverse (x^254, poly 0x11B); 0 maps to 0.
module aria_lt_gfinv (
  input  logic [7:0] gfinv_din,
  output logic [7:0] gfinv_dout
);

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = '0;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;

  // Addition chain for x^254: every exponent is built from earlier ones.
  always_comb begin
    x2         = gf_mul(gfinv_din, gfinv_din);
    x3         = gf_mul(x2, gfinv_din);
    x6         = gf_mul(x3, x3);
    x12        = gf_mul(x6, x6);
    x15        = gf_mul(x12, x3);
    x30        = gf_mul(x15, x15);
    x60        = gf_mul(x30, x30);
    x120       = gf_mul(x60, x60);
    x240       = gf_mul(x120, x120);
    x252       = gf_mul(x240, x12);
    gfinv_dout = gf_mul(x252, x2);
  end

endmodule

// File: rtl/aria_lt_s1.sv
// Forward ARIA S1 on one byte: field inverse followed by the affine map.
module aria_lt_s1
  import aria_lt_pkg::*;
(
  input  logic [7:0] s1_din,
  output logic [7:0] s1_dout
);

  logic [7:0] inv;

  aria_lt_gfinv u_gfinv (
    .gfinv_din  (s1_din),
    .gfinv_dout (inv)
  );

  // Affine map: each output bit folds in the four cyclically following bits.
  always_comb begin
    s1_dout = '0;
    for (int i = 0; i < 8; i++) begin
      s1_dout[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^
                   inv[(i + 6) % 8] ^ inv[(i + 7) % 8] ^ S1_CONST[i];
    end
  end

endmodule

// File: rtl/aria_lt_s1_seq.sv
// Iterative forward S1 engine: substitutes BPC bytes per clock in place,
// presenting the finished block with a valid/ready handshake.
module aria_lt_s1_seq
  import aria_lt_pkg::*;
#(
  parameter int BPC = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int NCYC = 16 / BPC;
  localparam int CW   = (NCYC > 1) ? $clog2(NCYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(NCYC - 1);

  if (!bpc_legal(BPC)) begin : g_bpc_check
    $error("aria_lt_s1_seq: BPC must be 1, 2, 4, 8 or 16");
  end

  lt_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [127:0]  work_q, work_d;
  logic [127:0]  sub_word;
  logic [7:0]    sub_din  [BPC];
  logic [7:0]    sub_dout [BPC];

  for (genvar j = 0; j < BPC; j++) begin : g_s1
    aria_lt_s1 u_s1 (
      .s1_din  (sub_din[j]),
      .s1_dout (sub_dout[j])
    );
  end

  // Pick the byte group addressed by the counter for the S1 lanes.
  always_comb begin
    for (int j = 0; j < BPC; j++) begin
      sub_din[j] = work_q[byte_lsb(int'(cnt_q) * BPC + j) +: 8];
    end
  end

  // Working word with the current byte group replaced by its substitution.
  always_comb begin
    sub_word = work_q;
    for (int j = 0; j < BPC; j++) begin
      sub_word[byte_lsb(int'(cnt_q) * BPC + j) +: 8] = sub_dout[j];
    end
  end

  // State, counter and working register; reset drops any block in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_d    = work_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          work_d  = in_data;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        work_d = sub_word;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_data = (state_q == DONE) ? work_q : '0;

endmodule

// File: tb/tb_aria_lt_s1_seq.sv
// Scoreboard bench for aria_lt_s1_seq at BPC = 4, 1 and 16.
module tb_aria_lt_s1_seq;

  localparam int ND = 3;
  localparam int BPC_TAB [ND] = '{4, 1, 16};

  logic          clk = 1'b0;
  logic          rst;
  logic [ND-1:0] in_valid;
  logic [ND-1:0] in_ready;
  logic [ND-1:0] out_valid;
  logic [ND-1:0] out_ready;
  logic [ND-1:0] busy;
  logic [127:0]  in_data  [ND];
  logic [127:0]  out_data [ND];

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [127:0] exp_q [ND][$];
  logic [127:0] in_q  [ND][$];
  int           acc_q [ND][$];

  logic [7:0] sbox     [256];
  logic [7:0] inv_sbox [256];

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [127:0] got, input logic [127:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h expected %h", name, got, want);
    end
  endtask

  task automatic failNow(input string name);
    n_checks++;
    n_fail++;
    $display("[TB] FAIL %s", name);
  endtask

  function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
    return (v << k) | (v >> (8 - k));
  endfunction

  // S1 table from log/antilog tables over generator 0x03, then the rotate form of the affine map.
  task automatic buildTables();
    logic [7:0] exp_t [255];
    int         log_t [256];
    logic [7:0] e;
    logic [7:0] y;
    logic [7:0] s;
    e = 8'h01;
    for (int i = 0; i < 256; i++) log_t[i] = 0;
    for (int i = 0; i < 255; i++) begin
      exp_t[i] = e;
      log_t[e] = i;
      e = e ^ ({e[6:0], 1'b0} ^ (e[7] ? 8'h1B : 8'h00));
    end
    for (int x = 0; x < 256; x++) begin
      y = (x == 0) ? 8'h00 : exp_t[(255 - log_t[x]) % 255];
      s = y ^ rotl(y, 1) ^ rotl(y, 2) ^ rotl(y, 3) ^ rotl(y, 4) ^ 8'h63;
      sbox[x]     = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] s1Block(input logic [127:0] d);
    logic [127:0] r;
    r = '0;
    for (int j = 0; j < 16; j++) r[127-8*j -: 8] = sbox[d[127-8*j -: 8]];
    return r;
  endfunction

  function automatic logic [127:0] randBlock();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  for (genvar g = 0; g < ND; g++) begin : lane
    localparam int NC = 16 / BPC_TAB[g];
    logic prev_ov;
    int a;
    logic [127:0] e, iw, r;

    aria_lt_s1_seq #(.BPC(BPC_TAB[g])) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .busy      (busy[g])
    );

    // Monitor: latency on each rising out_valid, stability under backpressure, data on handshake.
    always @(negedge clk) begin
      if (rst) begin
        prev_ov = 1'b0;
      end else begin
        if (out_valid[g] && !prev_ov) begin
          if (acc_q[g].size() == 0) failNow($sformatf("lane%0d_spurious_valid", g));
          else begin
            a = acc_q[g].pop_front();
            checkOutput($sformatf("lane%0d_latency", g), 128'(cyc - a + 1), 128'(NC + 1));
          end
        end
        if (out_valid[g]) begin
          if (exp_q[g].size() == 0) failNow($sformatf("lane%0d_unexpected_data", g));
          else if (!out_ready[g]) begin
            checkOutput($sformatf("lane%0d_stable", g), out_data[g], exp_q[g][0]);
          end else begin
            e  = exp_q[g].pop_front();
            iw = in_q[g].pop_front();
            checkOutput($sformatf("lane%0d_data", g), out_data[g], e);
            r = '0;
            for (int j = 0; j < 16; j++) r[127-8*j -: 8] = inv_sbox[out_data[g][127-8*j -: 8]];
            checkOutput($sformatf("lane%0d_inverse", g), r, iw);
          end
        end
        prev_ov = out_valid[g];
      end
    end
  end

  task automatic applyStimulus(input int d, input logic [127:0] data, input logic [127:0] want);
    int guard = 0;
    @(negedge clk);
    while (!in_ready[d] && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready[d]) begin
      failNow($sformatf("lane%0d_accept_timeout", d));
      return;
    end
    in_valid[d] = 1'b1;
    in_data[d]  = data;
    @(posedge clk);
    #1;
    in_valid[d] = 1'b0;
    acc_q[d].push_back(cyc);
    exp_q[d].push_back(want);
    in_q[d].push_back(data);
    checkOutput($sformatf("lane%0d_busy_after_accept", d), 128'(busy[d]), 128'(1));
    checkOutput($sformatf("lane%0d_ready_after_accept", d), 128'(in_ready[d]), 128'(0));
  endtask

  task automatic waitIdle(input int d);
    int guard = 0;
    while ((exp_q[d].size() != 0 || !in_ready[d]) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q[d].size() != 0 || !in_ready[d]) failNow($sformatf("lane%0d_drain_timeout", d));
  endtask

  task automatic checkIdleOutputs(input string tag, input int d);
    checkOutput($sformatf("%s_lane%0d_in_ready", tag, d), 128'(in_ready[d]), 128'(1));
    checkOutput($sformatf("%s_lane%0d_out_valid", tag, d), 128'(out_valid[d]), 128'(0));
    checkOutput($sformatf("%s_lane%0d_busy", tag, d), 128'(busy[d]), 128'(0));
    checkOutput($sformatf("%s_lane%0d_out_data", tag, d), out_data[d], 128'(0));
  endtask

  initial begin
    logic [127:0] blk;
    int guard;
    rst       = 1'b1;
    in_valid  = '0;
    out_ready = '1;
    for (int d = 0; d < ND; d++) in_data[d] = '0;
    buildTables();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    for (int d = 0; d < ND; d++) checkIdleOutputs("reset", d);

    $display("[TB] known-answer blocks");
    applyStimulus(0, 128'h0, {16{8'h63}});
    waitIdle(0);
    applyStimulus(0, {4{32'h000153FF}}, {4{32'h637CED16}});
    waitIdle(0);

    $display("[TB] byte sweep");
    for (int k = 0; k < 16; k++) begin
      for (int j = 0; j < 16; j++) blk[127-8*j -: 8] = 8'(16 * k + j);
      applyStimulus(0, blk, s1Block(blk));
    end
    waitIdle(0);

    $display("[TB] random blocks on all widths");
    for (int d = 0; d < ND; d++) begin
      for (int n = 0; n < 6; n++) begin
        blk = randBlock();
        applyStimulus(d, blk, s1Block(blk));
      end
      waitIdle(d);
    end

    $display("[TB] backpressure");
    out_ready[0] = 1'b0;
    blk = randBlock();
    applyStimulus(0, blk, s1Block(blk));
    guard = 0;
    while (!out_valid[0] && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!out_valid[0]) failNow("bp_valid_timeout");
    @(posedge clk);
    #1;
    for (int k = 0; k < 10; k++) begin
      in_valid[0] = 1'b1;
      in_data[0]  = randBlock();
      @(posedge clk);
      #1;
      checkOutput("bp_in_ready", 128'(in_ready[0]), 128'(0));
      checkOutput("bp_out_valid", 128'(out_valid[0]), 128'(1));
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("bp_release_in_ready", 128'(in_ready[0]), 128'(1));
    checkOutput("bp_release_out_valid", 128'(out_valid[0]), 128'(0));
    waitIdle(0);

    $display("[TB] reset during substitution");
    blk = randBlock();
    applyStimulus(0, blk, s1Block(blk));
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q[0].delete();
    acc_q[0].delete();
    in_q[0].delete();
    checkIdleOutputs("midreset", 0);
    blk = randBlock();
    applyStimulus(0, blk, s1Block(blk));
    for (int d = 0; d < ND; d++) waitIdle(d);
    repeat (4) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
